// File: rtl/dcache_plru_wb.sv
// N-way set-associative write-back data cache with tree pseudo-LRU replacement,
// a victim write-back FIFO toward memory and a flush engine that drains all dirty lines.
module dcache_plru_wb #(
    parameter int unsigned NUM_WAY   = 4,
    parameter int unsigned NUM_IDX   = 32,
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned WB_DEPTH  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rd_en,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic                 o_rd_hit,
    output logic [DATA_BITS-1:0] o_rd_data,
    input  logic                 i_st_en,
    input  logic [ADDR_BITS-1:0] i_st_addr,
    input  logic [DATA_BITS-1:0] i_st_data,
    output logic                 o_st_hit,
    input  logic                 i_fill_valid,
    output logic                 o_fill_ready,
    input  logic [ADDR_BITS-1:0] i_fill_addr,
    input  logic [DATA_BITS-1:0] i_fill_data,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [ADDR_BITS-1:0] o_wb_addr,
    output logic [DATA_BITS-1:0] o_wb_data,
    input  logic                 i_flush_req,
    output logic                 o_flush_busy,
    output logic                 o_flush_done,
    output logic                 o_cache_empty
);
    localparam int unsigned IW = $clog2(NUM_IDX);
    localparam int unsigned WW = $clog2(NUM_WAY);
    localparam int unsigned TW = ADDR_BITS - 3 - IW;
    localparam int unsigned NB = NUM_WAY - 1;
    localparam int unsigned PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned CW = $clog2(WB_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN} state_t;

    logic [NUM_WAY-1:0]   r_valid [NUM_IDX];
    logic [NUM_WAY-1:0]   r_dirty [NUM_IDX];
    logic [NB-1:0]        r_plru  [NUM_IDX];
    logic [TW-1:0]        r_tag   [NUM_IDX][NUM_WAY];
    logic [DATA_BITS-1:0] r_data  [NUM_IDX][NUM_WAY];

    logic [ADDR_BITS-1:0] r_wb_addr [WB_DEPTH];
    logic [DATA_BITS-1:0] r_wb_data [WB_DEPTH];
    logic [PW-1:0]        r_wp, r_rp;
    logic [CW-1:0]        r_wb_cnt;

    state_t               r_state;
    logic [IW-1:0]        r_fs_idx;
    logic [WW-1:0]        r_fs_way;
    logic                 r_done;

    logic [IW-1:0]        w_rd_idx, w_st_idx, w_fl_idx;
    logic [TW-1:0]        w_rd_tag, w_st_tag, w_fl_tag;
    logic                 w_rd_match, w_st_match, w_fl_hit;
    logic [WW-1:0]        w_rd_way, w_st_way, w_fl_hway, w_vict, w_fl_way;
    logic                 w_idle, w_full, w_fl_acc, w_st_hit, w_pop;
    logic                 w_fs_dirty, w_fs_adv, w_push;
    logic [ADDR_BITS-1:0] w_push_addr;
    logic [DATA_BITS-1:0] w_push_data;
    logic                 w_unused;

    assign w_rd_idx = i_rd_addr[3 +: IW];
    assign w_rd_tag = i_rd_addr[3+IW +: TW];
    assign w_st_idx = i_st_addr[3 +: IW];
    assign w_st_tag = i_st_addr[3+IW +: TW];
    assign w_fl_idx = i_fill_addr[3 +: IW];
    assign w_fl_tag = i_fill_addr[3+IW +: TW];
    assign w_unused = ^{i_rd_addr[2:0], i_st_addr[2:0], i_fill_addr[2:0]};

    always_comb begin
        w_rd_match = 1'b0;
        w_rd_way   = '0;
        w_st_match = 1'b0;
        w_st_way   = '0;
        w_fl_hit   = 1'b0;
        w_fl_hway  = '0;
        for (int unsigned w = 0; w < NUM_WAY; w++) begin
            if (r_valid[w_rd_idx][w] && r_tag[w_rd_idx][w] == w_rd_tag) begin
                w_rd_match = 1'b1;
                w_rd_way   = WW'(w);
            end
            if (r_valid[w_st_idx][w] && r_tag[w_st_idx][w] == w_st_tag) begin
                w_st_match = 1'b1;
                w_st_way   = WW'(w);
            end
            if (r_valid[w_fl_idx][w] && r_tag[w_fl_idx][w] == w_fl_tag) begin
                w_fl_hit  = 1'b1;
                w_fl_hway = WW'(w);
            end
        end
    end

    // Tree walk in heap order: node of level l on the path is (2^l - 1) + (upper l way bits).
    always_comb begin
        w_vict = '0;
        for (int unsigned l = 0; l < WW; l++)
            w_vict[WW-1-l] = r_plru[w_fl_idx][(1 << l) - 1 + (w_vict >> (WW - l))];
    end

    assign w_idle       = (r_state == S_IDLE);
    assign w_full       = (r_wb_cnt == CW'(WB_DEPTH));
    assign w_fl_acc     = i_fill_valid && o_fill_ready;
    assign w_fl_way     = w_fl_hit ? w_fl_hway : w_vict;
    assign w_st_hit     = i_st_en && w_st_match && w_idle &&
                          !(w_fl_acc && w_fl_idx == w_st_idx && w_fl_way == w_st_way);
    assign w_pop        = o_wb_valid && i_wb_ready;
    assign w_fs_dirty   = r_valid[r_fs_idx][r_fs_way] && r_dirty[r_fs_idx][r_fs_way];
    assign w_fs_adv     = !(w_fs_dirty && w_full);

    always_comb begin
        w_push      = 1'b0;
        w_push_addr = '0;
        w_push_data = '0;
        if (r_state == S_FLUSH) begin
            w_push      = w_fs_dirty && !w_full;
            w_push_addr = {r_tag[r_fs_idx][r_fs_way], r_fs_idx, 3'b000};
            w_push_data = r_data[r_fs_idx][r_fs_way];
        end else begin
            w_push      = w_fl_acc && !w_fl_hit && r_valid[w_fl_idx][w_vict] && r_dirty[w_fl_idx][w_vict];
            w_push_addr = {r_tag[w_fl_idx][w_vict], w_fl_idx, 3'b000};
            w_push_data = r_data[w_fl_idx][w_vict];
        end
    end

    always_comb begin
        o_cache_empty = 1'b1;
        for (int unsigned s = 0; s < NUM_IDX; s++)
            if (r_valid[s] != '0) o_cache_empty = 1'b0;
    end

    assign o_rd_hit     = i_rd_en && w_rd_match;
    assign o_rd_data    = o_rd_hit ? r_data[w_rd_idx][w_rd_way] : '0;
    assign o_st_hit     = w_st_hit;
    assign o_fill_ready = w_idle && !w_full;
    assign o_wb_valid   = (r_wb_cnt != '0);
    assign o_wb_addr    = r_wb_addr[r_rp];
    assign o_wb_data    = r_wb_data[r_rp];
    assign o_flush_busy = !w_idle;
    assign o_flush_done = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned s = 0; s < NUM_IDX; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
                for (int unsigned w = 0; w < NUM_WAY; w++) begin
                    r_tag[s][w]  <= '0;
                    r_data[s][w] <= '0;
                end
            end
            for (int unsigned e = 0; e < WB_DEPTH; e++) begin
                r_wb_addr[e] <= '0;
                r_wb_data[e] <= '0;
            end
            r_wp     <= '0;
            r_rp     <= '0;
            r_wb_cnt <= '0;
            r_state  <= S_IDLE;
            r_fs_idx <= '0;
            r_fs_way <= '0;
            r_done   <= 1'b0;
        end else begin
            // Per-bit writes in read, store, fill order so the last touch wins per node.
            if (o_rd_hit)
                for (int unsigned l = 0; l < WW; l++)
                    r_plru[w_rd_idx][(1 << l) - 1 + (w_rd_way >> (WW - l))] <= ~w_rd_way[WW-1-l];
            if (w_st_hit) begin
                r_data[w_st_idx][w_st_way]  <= i_st_data;
                r_dirty[w_st_idx][w_st_way] <= 1'b1;
                for (int unsigned l = 0; l < WW; l++)
                    r_plru[w_st_idx][(1 << l) - 1 + (w_st_way >> (WW - l))] <= ~w_st_way[WW-1-l];
            end
            if (w_fl_acc) begin
                r_valid[w_fl_idx][w_fl_way] <= 1'b1;
                r_dirty[w_fl_idx][w_fl_way] <= 1'b0;
                r_tag[w_fl_idx][w_fl_way]   <= w_fl_tag;
                r_data[w_fl_idx][w_fl_way]  <= i_fill_data;
                for (int unsigned l = 0; l < WW; l++)
                    r_plru[w_fl_idx][(1 << l) - 1 + (w_fl_way >> (WW - l))] <= ~w_fl_way[WW-1-l];
            end
            if (r_state == S_FLUSH && w_push)
                r_dirty[r_fs_idx][r_fs_way] <= 1'b0;

            if (w_push) begin
                r_wb_addr[r_wp] <= w_push_addr;
                r_wb_data[r_wp] <= w_push_data;
                r_wp <= (r_wp == PW'(WB_DEPTH - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= (r_rp == PW'(WB_DEPTH - 1)) ? '0 : r_rp + 1'b1;
            r_wb_cnt <= r_wb_cnt + CW'(w_push) - CW'(w_pop);

            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_flush_req) begin
                        r_state  <= S_FLUSH;
                        r_fs_idx <= '0;
                        r_fs_way <= '0;
                    end
                end
                S_FLUSH: begin
                    if (w_fs_adv) begin
                        if (r_fs_way == WW'(NUM_WAY - 1)) begin
                            r_fs_way <= '0;
                            if (r_fs_idx == IW'(NUM_IDX - 1))
                                r_state <= S_DRAIN;
                            else
                                r_fs_idx <= r_fs_idx + 1'b1;
                        end else begin
                            r_fs_way <= r_fs_way + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_wb_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
